// File: rtl/vec_pair_sequencer_if.sv
// Operand-pair input stream and result output stream of vec_pair_sequencer.
// A beat transfers on a rising clk edge where valid && ready. A producer holds valid and payload steady until that edge, and valid never waits on ready.
interface vec_pair_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/vec_pair_sequencer.sv
// Loads VECTOR_LEN operand pairs, kicks a vec_vec_to_vec engine, then streams its result vector out.
// Optional macro VEC_SEQ_TIMEOUT_EN aborts a RUN that lasts TIMEOUT_CYCLES and sets a sticky error flag.
module vec_pair_sequencer #(
   parameter int VECTOR_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   vec_pair_sequencer_if.slave        bus,
   output logic                       dut_rst,
   output logic [VECTOR_LEN-1:0][31:0] dut_vec1,
   output logic [VECTOR_LEN-1:0][31:0] dut_vec2,
   input  logic [VECTOR_LEN-1:0][31:0] dut_result,
   input  logic                       dut_done,
   output logic                       busy,
   output logic                       error,
   output logic [1:0]                 dbg_state
);

   if (VECTOR_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("vec_pair_sequencer: VECTOR_LEN must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      KICK  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                        state_q;
   logic [IDX_W-1:0]              wr_idx_q;
   logic [IDX_W-1:0]              rd_idx_q;
   logic [IDX_W-1:0]              rd_idx_d;
   logic                          in_ready_q;
   logic                          out_valid_q;
   logic                          out_last_q;
   logic [31:0]                   out_data_q;
   logic                          dut_rst_q;
   logic [VECTOR_LEN-1:0][31:0]   vec1_q;
   logic [VECTOR_LEN-1:0][31:0]   vec2_q;
   logic [VECTOR_LEN-1:0][31:0]   buf_q;
   logic                          in_fire;
   logic                          out_fire;

`ifdef VEC_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tcnt_q;
   logic             error_q;
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign in_fire  = bus.in_valid && in_ready_q;
   assign out_fire = out_valid_q && bus.out_ready;
   assign rd_idx_d = rd_idx_q + 1'b1;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign dut_rst       = dut_rst_q;
   assign dut_vec1      = vec1_q;
   assign dut_vec2      = vec2_q;
   assign busy          = (state_q != LOAD);
   assign dbg_state     = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         dut_rst_q   <= 1'b1;
         vec1_q      <= '0;
         vec2_q      <= '0;
         buf_q       <= '0;
`ifdef VEC_SEQ_TIMEOUT_EN
         tcnt_q      <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         // The engine start pulse is only ever held for the single KICK cycle.
         dut_rst_q <= 1'b0;
         case (state_q)
            LOAD: begin
               in_ready_q <= 1'b1;
               if (in_fire) begin
                  vec1_q[wr_idx_q] <= bus.in_a;
                  vec2_q[wr_idx_q] <= bus.in_b;
`ifdef VEC_SEQ_TIMEOUT_EN
                  error_q <= 1'b0;
`endif
                  if (wr_idx_q == LAST_IDX) begin
                     wr_idx_q   <= '0;
                     in_ready_q <= 1'b0;
                     dut_rst_q  <= 1'b1;
                     state_q    <= KICK;
                  end else begin
                     wr_idx_q <= wr_idx_q + 1'b1;
                  end
               end
            end
            KICK: begin
`ifdef VEC_SEQ_TIMEOUT_EN
               tcnt_q <= '0;
`endif
               state_q <= RUN;
            end
            RUN: begin
               // A done arriving on the timeout cycle still wins.
               if (dut_done) begin
                  buf_q       <= dut_result;
                  out_valid_q <= 1'b1;
                  out_data_q  <= dut_result[0];
                  out_last_q  <= (LAST_IDX == '0);
                  state_q     <= DRAIN;
               end
`ifdef VEC_SEQ_TIMEOUT_EN
               else if (tcnt_q == TO_LAST) begin
                  error_q    <= 1'b1;
                  in_ready_q <= 1'b1;
                  state_q    <= LOAD;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
`endif
            end
            DRAIN: begin
               if (out_fire) begin
                  if (rd_idx_q == LAST_IDX) begin
                     rd_idx_q    <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= LOAD;
                  end else begin
                     rd_idx_q   <= rd_idx_d;
                     out_data_q <= buf_q[rd_idx_d];
                     out_last_q <= (rd_idx_d == LAST_IDX);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_pair_sequencer.sv
// Directed bench for vec_pair_sequencer with a Hadamard-product engine model and a result scoreboard.
module tb_vec_pair_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_pair_sequencer_if bus0();
  vec_pair_sequencer_if bus1();

  logic              dut_rst0;
  logic [3:0][31:0]  vec1_0, vec2_0;
  logic [3:0][31:0]  result0 = '0;
  logic              done0 = 1'b0;
  logic              busy0, error0;
  logic [1:0]        state0;

  logic              dut_rst1;
  logic [0:0][31:0]  vec1_1, vec2_1;
  logic [0:0][31:0]  result1 = '0;
  logic              done1 = 1'b0;
  logic              busy1, error1;
  logic [1:0]        state1;

  vec_pair_sequencer #(.VECTOR_LEN(4), .TIMEOUT_CYCLES(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .dut_rst(dut_rst0), .dut_vec1(vec1_0), .dut_vec2(vec2_0),
    .dut_result(result0), .dut_done(done0),
    .busy(busy0), .error(error0), .dbg_state(state0)
  );

  vec_pair_sequencer #(.VECTOR_LEN(1), .TIMEOUT_CYCLES(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .dut_rst(dut_rst1), .dut_vec1(vec1_1), .dut_vec2(vec2_1),
    .dut_result(result1), .dut_done(done1),
    .busy(busy1), .error(error1), .dbg_state(state1)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  int kicks0 = 0, kicks1 = 0, run_cnt0 = 0;
  int eng_lat = 3;
  logic eng_stuck = 1'b0;
  logic rdy_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;

  localparam logic [3:0][31:0] V1A = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [3:0][31:0] V1B = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
  localparam logic [3:0][31:0] V1R = {32'h42000000, 32'h41A80000, 32'h41400000, 32'h40A00000};
  localparam logic [3:0][31:0] V2A = {32'h41200000, 32'h40000000, 32'h3F000000, 32'hBFC00000};
  localparam logic [3:0][31:0] V2B = {32'h40400000, 32'h3E800000, 32'h40800000, 32'h40000000};
  localparam logic [3:0][31:0] V2R = {32'h41F00000, 32'h3F000000, 32'h40000000, 32'hC0400000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic real fp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    return r2fp(fp2r(x) * fp2r(y));
  endfunction

  // Engine models: restart on dut_rst, raise done eng_lat cycles later with element-wise products.
  logic [3:0] eng_cnt0 = '0;
  always @(posedge clk) begin
    if (dut_rst0) begin
      eng_cnt0 <= '0;
      done0    <= 1'b0;
    end else if (!done0 && !eng_stuck) begin
      if (eng_cnt0 == 4'(eng_lat)) begin
        done0 <= 1'b1;
        for (int i = 0; i < 4; i++) result0[i] <= fp_mul(vec1_0[i], vec2_0[i]);
      end else begin
        eng_cnt0 <= eng_cnt0 + 1'b1;
      end
    end
  end

  logic [3:0] eng_cnt1 = '0;
  always @(posedge clk) begin
    if (dut_rst1) begin
      eng_cnt1 <= '0;
      done1    <= 1'b0;
    end else if (!done1) begin
      if (eng_cnt1 == 4'(eng_lat)) begin
        done1      <= 1'b1;
        result1[0] <= fp_mul(vec1_1[0], vec2_1[0]);
      end else begin
        eng_cnt1 <= eng_cnt1 + 1'b1;
      end
    end
  end

  // Output ready drivers change just after the active edge.
  initial begin
    int pidx = 0;
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus0.out_ready = rdy_mode ? rdy_pat[pidx % 4] : 1'b1;
      pidx++;
    end
  end

  // Monitor for the VECTOR_LEN=4 instance.
  initial begin
    logic stall_pend = 1'b0;
    logic [32:0] stall_val = '0;
    logic [32:0] e;
    logic done_seen = 1'b0;
    logic prev_rst = 1'b0;
    logic [3:0][31:0] snap1 = '0, snap2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
        done_seen  = 1'b0;
      end else begin
        if (done_seen) check("latency out_valid", bus0.out_valid, 1);
        done_seen = (state0 == 2'd2) && done0;
        if (bus0.out_valid) begin
          if (stall_pend) check("stall hold", {bus0.out_last, bus0.out_data}, stall_val);
          if (bus0.out_ready) begin
            stall_pend = 1'b0;
            if (exp0_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL out0 unexpected: got 0x%0h expected none", {bus0.out_last, bus0.out_data});
            end else begin
              e = exp0_q.pop_front();
              check("out0 last/data", {bus0.out_last, bus0.out_data}, e);
            end
          end else begin
            stall_pend = 1'b1;
            stall_val  = {bus0.out_last, bus0.out_data};
          end
        end else begin
          if (stall_pend) check("out0 dropped while stalled", 0, 1);
          stall_pend = 1'b0;
        end
        if (state0 == 2'd1) begin
          snap1 = vec1_0;
          snap2 = vec2_0;
          run_cnt0 = 0;
        end
        if (state0 == 2'd2) run_cnt0++;
        if (dut_rst0 && prev_rst) kicks0++;
        if (busy0) check("in_ready while busy", bus0.in_ready, 0);
        if (state0 == 2'd2 || state0 == 2'd3)
          check("operands stable", (vec1_0 == snap1) && (vec2_0 == snap2), 1);
      end
      prev_rst = rst_n;
    end
  end

  // Monitor for the VECTOR_LEN=1 instance.
  initial begin
    logic [32:0] e;
    logic prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dut_rst1 && prev_rst) kicks1++;
        if (bus1.out_valid && bus1.out_ready) begin
          if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out1 unexpected: got 0x%0h expected none", {bus1.out_last, bus1.out_data});
          end else begin
            e = exp1_q.pop_front();
            check("out1 last/data", {bus1.out_last, bus1.out_data}, e);
          end
        end
      end
      prev_rst = rst_n;
    end
  end

  task automatic send0(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_a = a;
    bus0.in_b = b;
    while (!bus0.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send0 in_ready timeout", 0, 1);
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
  endtask

  task automatic send_vec0(input logic [3:0][31:0] a, input logic [3:0][31:0] b, input bit hold);
    int n = 0;
    for (int i = 0; i < 4; i++) send0(a[i], b[i]);
    if (hold) begin
      while (n < 400) begin
        @(negedge clk);
        if (!busy0) break;
        bus0.in_valid = 1'b1;
        bus0.in_a = $urandom;
        bus0.in_b = $urandom;
        n++;
      end
      bus0.in_valid = 1'b0;
    end
  endtask

  task automatic push_exp0(input logic [3:0][31:0] r);
    for (int i = 0; i < 4; i++) exp0_q.push_back({(i == 3) ? 1'b1 : 1'b0, r[i]});
  endtask

  task automatic wait_idle0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || exp0_q.size() != 0) && n < 400);
    if (n >= 400) check("wait_idle0 timeout", 0, 1);
  endtask

  task automatic check_reset0();
    check("rst in_ready", bus0.in_ready, 0);
    check("rst dut_rst", dut_rst0, 1);
    check("rst out_valid", bus0.out_valid, 0);
    check("rst out_data", bus0.out_data, 0);
    check("rst out_last", bus0.out_last, 0);
    check("rst busy", busy0, 0);
    check("rst error", error0, 0);
    check("rst state", state0, 0);
    check("rst vec1 zero", vec1_0 == '0, 1);
    check("rst vec2 zero", vec2_0 == '0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
    repeat (3) @(negedge clk);
    check_reset0();
    check("rst out1 valid", bus1.out_valid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("dut_rst held until edge", dut_rst0, 1);
    @(posedge clk);
    #1;
    check("dut_rst released", dut_rst0, 0);
    check("in_ready after reset", bus0.in_ready, 1);

    // Basic Hadamard product, ready always high.
    kicks0 = 0;
    push_exp0(V1R);
    send_vec0(V1A, V1B, 1'b0);
    wait_idle0();
    check("kicks vec1", kicks0, 1);

    // Stalled drain with in_valid held high and changing through the busy phase.
    kicks0 = 0;
    rdy_mode = 1'b1;
    push_exp0(V2R);
    send_vec0(V2A, V2B, 1'b1);
    wait_idle0();
    rdy_mode = 1'b0;
    check("kicks vec2", kicks0, 1);
    check("vec1 untouched by held in_valid", vec1_0 == V2A, 1);
    check("vec2 untouched by held in_valid", vec2_0 == V2B, 1);

    // Reset after two of four loads discards the partial vector.
    send0(V2A[0], V2B[0]);
    send0(V2A[1], V2B[1]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset0();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    kicks0 = 0;
    push_exp0(V1R);
    send_vec0(V1A, V1B, 1'b0);
    wait_idle0();
    check("kicks after reset", kicks0, 1);

`ifdef VEC_SEQ_TIMEOUT_EN
    // Engine never finishes: abort after 8 RUN cycles with no output.
    eng_stuck = 1'b1;
    send_vec0(V1A, V1B, 1'b0);
    n = 0;
    while (!error0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout error set", error0, 1);
    check("timeout run cycles", run_cnt0, 8);
    check("timeout state LOAD", state0, 0);
    check("timeout no out_valid", bus0.out_valid, 0);
    eng_stuck = 1'b0;
    push_exp0(V2R);
    send0(V2A[0], V2B[0]);
    check("error cleared by handshake", error0, 0);
    for (int i = 1; i < 4; i++) send0(V2A[i], V2B[i]);
    wait_idle0();
`else
    check("error tied low", error0, 0);
`endif

    // VECTOR_LEN=1 instance: one load, one pulse, one last-marked output.
    exp1_q.push_back({1'b1, 32'h40C00000});
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_a = 32'h40000000;
    bus1.in_b = 32'h40400000;
    n = 0;
    while (!bus1.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    check("vl1 enters KICK", state1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy1 || exp1_q.size() != 0) && n < 400);
    if (n >= 400) check("vl1 idle timeout", 0, 1);
    check("vl1 kicks", kicks1, 1);

    repeat (3) @(negedge clk);
    check("exp0 queue drained", exp0_q.size(), 0);
    check("exp1 queue drained", exp1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
